// File: rtl/answer_timer.sv
// ---------------------------------------------------------------------------
// answer_timer
//   Quiz-buzzer round timer. After a host start, counts a BCD seconds value
//   down from ROUND_SEC once every CLK_HZ clock cycles. Locks the first valid
//   responder press, or enters TIMEOUT when the display reaches 00. The host
//   returns the block to IDLE with clear.
//
//   Optional feature: define ANSWER_TIMER_WARN_BEEP_EN to drive warn high
//   while counting with 01..05 seconds remaining. Without the macro warn is
//   tied low and no comparator is built.
//
// Parameters
//   CLK_HZ     clk cycles per displayed second (>= 2)
//   ROUND_SEC  round length in seconds (1..99)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      host request to begin a round (level)
//   clear      host request to abandon or finish a round (level)
//   stoptimer  responder has registered a valid first press
//   result     responder winner code, 1..4 accepted
//   showready  high only in IDLE; clears the responder's result
//   sec_tens   BCD tens digit of the remaining seconds
//   sec_ones   BCD ones digit of the remaining seconds
//   winner     latched winner code, 0 when none
//   timeout    high while in TIMEOUT
//   warn       final-seconds warning (see macro above)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module answer_timer #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned ROUND_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic       stoptimer,
    input  logic [3:0] result,
    output logic       showready,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] winner,
    output logic       timeout,
    output logic       warn
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0] INIT_TENS = 4'(ROUND_SEC / 10);
    localparam logic [3:0] INIT_ONES = 4'(ROUND_SEC % 10);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_LOCKED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    winner_q, winner_d;
    logic          showready_q, showready_d;
    logic          timeout_q, timeout_d;
    logic          warn_q, warn_d;

    logic          tick_c;
    logic          res_valid_c;

    assign tick_c      = (presc_q == PRESC_MAX);
    assign res_valid_c = (result != 4'd0) && (result <= 4'd4);

    // State, prescaler, BCD digits and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            tens_q      <= INIT_TENS;
            ones_q      <= INIT_ONES;
            winner_q    <= 4'd0;
            showready_q <= 1'b1;
            timeout_q   <= 1'b0;
            warn_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            winner_q    <= winner_d;
            showready_q <= showready_d;
            timeout_q   <= timeout_d;
            warn_q      <= warn_d;
        end
    end

    // Next-state, prescaler and BCD countdown
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        winner_d = winner_q;

        case (state_q)
            S_IDLE: begin
                presc_d  = '0;
                tens_d   = INIT_TENS;
                ones_d   = INIT_ONES;
                winner_d = 4'd0;
                if (start && !clear) begin
                    state_d = S_COUNT;
                end
            end

            S_COUNT: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    presc_d  = '0;
                    tens_d   = INIT_TENS;
                    ones_d   = INIT_ONES;
                    winner_d = 4'd0;
                end else if (stoptimer && res_valid_c) begin
                    // A press beats a coinciding tick: digits stay at the
                    // pre-tick value and TIMEOUT is never reached.
                    state_d  = S_LOCKED;
                    winner_d = result;
                end else if (tick_c) begin
                    presc_d = '0;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                    if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
                        state_d = S_TIMEOUT;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_LOCKED, S_TIMEOUT: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    presc_d  = '0;
                    tens_d   = INIT_TENS;
                    ones_d   = INIT_ONES;
                    winner_d = 4'd0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                presc_d  = '0;
                tens_d   = INIT_TENS;
                ones_d   = INIT_ONES;
                winner_d = 4'd0;
            end
        endcase
    end

    // Status flags follow the next state so they line up with the digits
    always_comb begin
        showready_d = (state_d == S_IDLE);
        timeout_d   = (state_d == S_TIMEOUT);
`ifdef ANSWER_TIMER_WARN_BEEP_EN
        warn_d      = (state_d == S_COUNT) && (tens_d == 4'd0) &&
                      (ones_d != 4'd0) && (ones_d <= 4'd5);
`else
        warn_d      = 1'b0;
`endif
    end

    assign showready = showready_q;
    assign sec_tens  = tens_q;
    assign sec_ones  = ones_q;
    assign winner    = winner_q;
    assign timeout   = timeout_q;
    assign warn      = warn_q;

endmodule

// File: tb/tb_answer_timer.sv
// ---------------------------------------------------------------------------
// tb_answer_timer
//   Drives answer_timer (CLK_HZ=4, ROUND_SEC=12) with directed and random
//   host/responder activity. A reference model tracks the round as a plain
//   integer seconds count and pushes the expected outputs for every clock
//   edge into a queue; a separate monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_answer_timer;

    localparam int unsigned CLK_HZ    = 4;
    localparam int unsigned ROUND_SEC = 12;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_LOCKED  = 2;
    localparam int M_TIMEOUT = 3;

    typedef struct packed {
        logic       showready;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [3:0] winner;
        logic       timeout;
        logic       warn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       stoptimer = 1'b0;
    logic [3:0] result = 4'd0;
    logic       showready;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] winner;
    logic       timeout;
    logic       warn;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];

    // Reference model: whole seconds remaining, cycles elapsed in this second
    int m_mode = M_IDLE;
    int m_rem  = ROUND_SEC;
    int m_cyc  = 0;
    int m_win  = 0;

    answer_timer #(
        .CLK_HZ   (CLK_HZ),
        .ROUND_SEC(ROUND_SEC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear    (clear),
        .stoptimer(stoptimer),
        .result   (result),
        .showready(showready),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .winner   (winner),
        .timeout  (timeout),
        .warn     (warn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.showready = (m_mode == M_IDLE);
        e.tens      = 4'(m_rem / 10);
        e.ones      = 4'(m_rem % 10);
        e.winner    = 4'(m_win);
        e.timeout   = (m_mode == M_TIMEOUT);
`ifdef ANSWER_TIMER_WARN_BEEP_EN
        e.warn      = (m_mode == M_RUN) && (m_rem >= 1) && (m_rem <= 5);
`else
        e.warn      = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_rem  = ROUND_SEC;
        m_cyc  = 0;
        m_win  = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit st, input int r);
        case (m_mode)
            M_IDLE: begin
                if (s && !c) begin
                    m_mode = M_RUN;
                    m_cyc  = 0;
                    m_rem  = ROUND_SEC;
                end
            end
            M_RUN: begin
                if (c) begin
                    model_reset();
                end else if (st && r >= 1 && r <= 4) begin
                    m_mode = M_LOCKED;
                    m_win  = r;
                end else if (m_cyc == CLK_HZ - 1) begin
                    m_cyc = 0;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = M_TIMEOUT;
                end else begin
                    m_cyc = m_cyc + 1;
                end
            end
            default: begin
                if (c) model_reset();
            end
        endcase
    endtask

    // One clock of stimulus; the expected outputs after the next edge are queued
    task automatic step(input bit s, input bit c, input bit st, input int r);
        @(negedge clk);
        rst       = 1'b1;
        start     = s;
        clear     = c;
        stoptimer = st;
        result    = 4'(r);
        model_step(s, c, st, r);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Reset asserted between edges: outputs must change without a clock
    task automatic pulse_reset();
        exp_t e;
        @(negedge clk);
        start     = 1'b0;
        clear     = 1'b0;
        stoptimer = 1'b0;
        result    = 4'd0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        e = model_out();
        chk("rst_showready", 32'(showready), 32'(e.showready));
        chk("rst_tens",      32'(sec_tens),  32'(e.tens));
        chk("rst_ones",      32'(sec_ones),  32'(e.ones));
        chk("rst_winner",    32'(winner),    32'(e.winner));
        chk("rst_timeout",   32'(timeout),   32'(e.timeout));
        chk("rst_warn",      32'(warn),      32'(e.warn));
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the queued expectation after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("showready", 32'(showready), 32'(e.showready));
                chk("sec_tens",  32'(sec_tens),  32'(e.tens));
                chk("sec_ones",  32'(sec_ones),  32'(e.ones));
                chk("winner",    32'(winner),    32'(e.winner));
                chk("timeout",   32'(timeout),   32'(e.timeout));
                chk("warn",      32'(warn),      32'(e.warn));
            end
        end
    end

    initial begin
        int guard;
        bit s, c, st;
        int r;

        repeat (2) @(negedge clk);
        pulse_reset();
        idle_steps(2);

        // Full round to TIMEOUT, hold, then clear
        step(1, 0, 0, 0);
        idle_steps(52);
        step(0, 0, 1, 2);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        idle_steps(2);

        // Press with result 3 at cycle 10, noise while locked, then clear
        step(1, 0, 0, 0);
        idle_steps(9);
        step(0, 0, 1, 3);
        idle_steps(3);
        step(1, 0, 1, 1);
        step(0, 1, 0, 0);
        idle_steps(2);

        // Press on the very tick that would reach 00
        step(1, 0, 0, 0);
        guard = 0;
        while (!(m_mode == M_RUN && m_rem == 1 && m_cyc == CLK_HZ - 1) && guard < 200) begin
            step(0, 0, 0, 0);
            guard++;
        end
        chk("reach_last_tick", 32'(guard < 200), 32'd1);
        step(0, 0, 1, 2);
        idle_steps(6);
        step(0, 1, 0, 0);
        idle_steps(1);

        // Invalid result codes ignored, then clear beats press
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 7);
        step(0, 0, 1, 5);
        idle_steps(3);
        step(0, 1, 1, 4);
        idle_steps(2);

        // Start held across the return to IDLE begins a new round
        step(1, 0, 0, 0);
        idle_steps(4);
        step(0, 0, 1, 1);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        idle_steps(6);

        // Reset mid-round discards it; no activity until a fresh start
        pulse_reset();
        idle_steps(5);
        step(0, 0, 1, 2);
        idle_steps(2);

        // Randomised activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                s  = ($urandom_range(0, 7) == 0);
                c  = ($urandom_range(0, 59) == 0);
                st = ($urandom_range(0, 29) == 0);
                r  = int'($urandom_range(0, 7));
                if (m_mode == M_IDLE && s) c = 1'b0;
                step(s, c, st, r);
            end
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
